mdu_seq_ctrl: RTL and testbench

MDU_SEQ_CTRL -- requirements
Module: mdu_seq_ctrl

---
 rtl/mdu_seq_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_mdu_seq_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mdu_seq_ctrl
// Description : Sequencing controller for an iterative multiply/divide unit.
//               Accepts an M-extension instruction from Execute, latches the
//               operation controls, drives the datapath load/step strobes,
//               stalls the front of the pipeline while the unit iterates and
//               hands the result to the E->M register when finished.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_seq_ctrl #(
  parameter int ITERS = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       md_validE,
  input  logic [2:0] md_funct3E,
  input  logic       opB_zeroE,
  input  logic       flushE,
  input  logic       mem_stallM,
  output logic       dp_load,
  output logic       dp_step,
  output logic       dp_is_div,
  output logic       dp_signed_a,
  output logic       dp_signed_b,
  output logic       dp_upper,
  output logic       dp_divzero,
  output logic [5:0] iter_cnt,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       flushM,
  output logic       md_doneE,
  output logic       busy
);

  // Step count at which the final iteration is performed.
  localparam logic [5:0] C_LAST_STEP = 6'(ITERS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [5:0] r_iter_cnt;
  logic [5:0] w_iter_cnt_nxt;

  logic r_is_div;
  logic r_signed_a;
  logic r_signed_b;
  logic r_upper;
  logic r_divzero;
  logic w_is_div_nxt;
  logic w_signed_a_nxt;
  logic w_signed_b_nxt;
  logic w_upper_nxt;
  logic w_divzero_nxt;

  logic w_dec_signed_a;
  logic w_dec_signed_b;
  logic w_dec_upper;
  logic w_accept;
  logic w_stall;

  // Decode the operand signedness and result half from funct3.
  always_comb begin
    w_dec_signed_a = 1'b0;
    w_dec_signed_b = 1'b0;
    w_dec_upper    = 1'b0;
    case (md_funct3E)
      3'b000: begin w_dec_signed_a = 1'b1; w_dec_signed_b = 1'b1; end
      3'b001: begin w_dec_signed_a = 1'b1; w_dec_signed_b = 1'b1; w_dec_upper = 1'b1; end
      3'b010: begin w_dec_signed_a = 1'b1; w_dec_upper = 1'b1; end
      3'b011: begin w_dec_upper = 1'b1; end
      3'b100: begin w_dec_signed_a = 1'b1; w_dec_signed_b = 1'b1; end
      3'b101: begin end
      3'b110: begin w_dec_signed_a = 1'b1; w_dec_signed_b = 1'b1; w_dec_upper = 1'b1; end
      default: begin w_dec_upper = 1'b1; end
    endcase
  end

  // An instruction is taken only outside reset so outputs stay low while rst is asserted.
  assign w_accept = rst && md_validE && !flushE;

  // Next-state, counter, latch and pipeline-control logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_iter_cnt_nxt = r_iter_cnt;
    w_is_div_nxt   = r_is_div;
    w_signed_a_nxt = r_signed_a;
    w_signed_b_nxt = r_signed_b;
    w_upper_nxt    = r_upper;
    w_divzero_nxt  = r_divzero;
    dp_load        = 1'b0;
    dp_step        = 1'b0;
    w_stall        = 1'b0;
    flushM         = 1'b0;
    md_doneE       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          dp_load        = 1'b1;
          w_stall        = 1'b1;
          flushM         = 1'b1;
          w_iter_cnt_nxt = 6'd0;
          w_is_div_nxt   = md_funct3E[2];
          w_signed_a_nxt = w_dec_signed_a;
          w_signed_b_nxt = w_dec_signed_b;
          w_upper_nxt    = w_dec_upper;
          // Division by zero has a fixed architectural result; skip iterating.
          if (md_funct3E[2] && opB_zeroE) begin
            w_divzero_nxt = 1'b1;
            w_state_nxt   = S_DONE;
          end else begin
            w_divzero_nxt = 1'b0;
            w_state_nxt   = S_BUSY;
          end
        end
      end

      S_BUSY: begin
        if (flushE) begin
          flushM      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          dp_step        = 1'b1;
          w_stall        = 1'b1;
          flushM         = 1'b1;
          w_iter_cnt_nxt = r_iter_cnt + 6'd1;
          if (r_iter_cnt == C_LAST_STEP) begin
            w_state_nxt = S_DONE;
          end
        end
      end

      S_DONE: begin
        if (flushE) begin
          // A flush kills the result even if the memory stage is holding.
          flushM      = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          md_doneE = 1'b1;
          if (mem_stallM) begin
            w_stall = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Returning to IDLE clears the count and controls so an idle unit presents all zeros.
    if ((r_state != S_IDLE) && (w_state_nxt == S_IDLE)) begin
      w_iter_cnt_nxt = 6'd0;
      w_is_div_nxt   = 1'b0;
      w_signed_a_nxt = 1'b0;
      w_signed_b_nxt = 1'b0;
      w_upper_nxt    = 1'b0;
      w_divzero_nxt  = 1'b0;
    end
  end

  // State, iteration count and operation-control registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_iter_cnt <= 6'd0;
      r_is_div   <= 1'b0;
      r_signed_a <= 1'b0;
      r_signed_b <= 1'b0;
      r_upper    <= 1'b0;
      r_divzero  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_iter_cnt <= w_iter_cnt_nxt;
      r_is_div   <= w_is_div_nxt;
      r_signed_a <= w_signed_a_nxt;
      r_signed_b <= w_signed_b_nxt;
      r_upper    <= w_upper_nxt;
      r_divzero  <= w_divzero_nxt;
    end
  end

  assign stallF      = w_stall;
  assign stallD      = w_stall;
  assign stallE      = w_stall;
  assign iter_cnt    = r_iter_cnt;
  assign dp_is_div   = r_is_div;
  assign dp_signed_a = r_signed_a;
  assign dp_signed_b = r_signed_b;
  assign dp_upper    = r_upper;
  assign dp_divzero  = r_divzero;
  assign busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mdu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_seq_ctrl
// Description : Directed self-checking bench for mdu_seq_ctrl (ITERS=32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       md_validE;
  logic [2:0] md_funct3E;
  logic       opB_zeroE;
  logic       flushE;
  logic       mem_stallM;
  logic       dp_load, dp_step, dp_is_div, dp_signed_a, dp_signed_b, dp_upper, dp_divzero;
  logic [5:0] iter_cnt;
  logic       stallF, stallD, stallE, flushM, md_doneE, busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mdu_seq_ctrl #(.ITERS(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .md_validE  (md_validE),
    .md_funct3E (md_funct3E),
    .opB_zeroE  (opB_zeroE),
    .flushE     (flushE),
    .mem_stallM (mem_stallM),
    .dp_load    (dp_load),
    .dp_step    (dp_step),
    .dp_is_div  (dp_is_div),
    .dp_signed_a(dp_signed_a),
    .dp_signed_b(dp_signed_b),
    .dp_upper   (dp_upper),
    .dp_divzero (dp_divzero),
    .iter_cnt   (iter_cnt),
    .stallF     (stallF),
    .stallD     (stallD),
    .stallE     (stallE),
    .flushM     (flushM),
    .md_doneE   (md_doneE),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen mid-cycle.
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #3;
  endtask

  task automatic idle_inputs;
    md_validE  = 1'b0;
    md_funct3E = 3'b000;
    opB_zeroE  = 1'b0;
    flushE     = 1'b0;
    mem_stallM = 1'b0;
  endtask

  task automatic accept(input logic [2:0] f, input logic z);
    md_validE  = 1'b1;
    md_funct3E = f;
    opB_zeroE  = z;
    flushE     = 1'b0;
    mem_stallM = 1'b0;
  endtask

  // Helper views: {busy,dp_load,dp_step,md_doneE,flushM,stallF,stallD,stallE}
  // and {dp_is_div,dp_signed_a,dp_signed_b,dp_upper,dp_divzero}.
  initial begin
    rst = 1'b0;
    idle_inputs();
    #2;
    chk("reset_outs", {busy, dp_load, dp_step, md_doneE, flushM, stallF, stallD, stallE}, 8'h00);
    chk("reset_cnt_latch", {iter_cnt, dp_is_div, dp_signed_a, dp_signed_b, dp_upper, dp_divzero}, 11'h000);
    md_validE = 1'b1;
    #1;
    chk("reset_no_load", {dp_load, stallE, flushM}, 3'b000);
    md_validE = 1'b0;
    cyc(); cyc();
    rst = 1'b1;
    settle();

    // Valid instruction killed by flush in IDLE: nothing happens.
    cyc(); md_validE = 1'b1; flushE = 1'b1; settle();
    chk("idle_flush_outs", {busy, dp_load, dp_step, md_doneE, flushM, stallF, stallD, stallE}, 8'h00);
    cyc(); idle_inputs(); settle();
    chk("idle_flush_busy", {busy, iter_cnt}, 7'h00);

    // MUL full run.
    cyc(); accept(3'b000, 1'b0); settle();
    chk("mul_c0", {dp_load, dp_step, stallF, stallD, stallE, flushM, md_doneE}, 7'b1011110);
    for (int i = 1; i <= 32; i++) begin
      cyc(); idle_inputs(); settle();
      chk("mul_step", {dp_step, dp_load, md_doneE, stallE, flushM, busy, iter_cnt},
          {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'(i - 1)});
    end
    cyc(); settle();
    chk("mul_done", {md_doneE, stallF, stallD, stallE, flushM, dp_step, iter_cnt},
        {1'b1, 5'b00000, 6'd32});
    chk("mul_latch", {dp_is_div, dp_signed_a, dp_signed_b, dp_upper, dp_divzero}, 5'b01100);
    cyc(); settle();
    chk("mul_idle", {busy, md_doneE, iter_cnt}, 8'h00);

    // DIVU by zero: one-cycle latency, no steps.
    cyc(); accept(3'b101, 1'b1); settle();
    chk("divz_c0", {dp_load, dp_step, stallF, stallD, stallE, flushM, busy}, 7'b1011110);
    cyc(); idle_inputs(); settle();
    chk("divz_c1", {md_doneE, dp_step, stallF, stallD, stallE, flushM}, 6'b100000);
    chk("divz_latch", {dp_is_div, dp_signed_a, dp_signed_b, dp_upper, dp_divzero}, 5'b10001);
    cyc(); settle();
    chk("divz_idle", {busy, md_doneE, dp_divzero}, 3'b000);

    // MULH aborted by flush at cycle 10.
    cyc(); accept(3'b001, 1'b0); settle();
    chk("mulh_c0", dp_load, 1'b1);
    for (int i = 1; i <= 9; i++) begin
      cyc(); idle_inputs(); settle();
    end
    cyc(); flushE = 1'b1; settle();
    chk("mulh_flush", {stallF, stallD, stallE, flushM, dp_step, md_doneE}, 6'b000100);
    cyc(); flushE = 1'b0; settle();
    chk("mulh_after", {busy, md_doneE, iter_cnt}, 8'h00);

    // REM held 3 cycles in DONE by the memory stage.
    cyc(); accept(3'b110, 1'b0); settle();
    for (int i = 1; i <= 32; i++) begin
      cyc(); idle_inputs(); settle();
    end
    for (int i = 0; i < 3; i++) begin
      cyc(); mem_stallM = 1'b1; settle();
      chk("rem_hold", {md_doneE, stallF, stallD, stallE, flushM, busy}, 6'b111101);
      chk("rem_latch", {dp_is_div, dp_signed_a, dp_signed_b, dp_upper, dp_divzero}, 5'b11110);
    end
    cyc(); mem_stallM = 1'b0; settle();
    chk("rem_release", {md_doneE, stallF, stallD, stallE, flushM}, 5'b10000);
    cyc(); settle();
    chk("rem_idle", {busy, md_doneE}, 2'b00);

    // Flush beats memory hold in DONE.
    cyc(); accept(3'b100, 1'b1); settle();
    cyc(); idle_inputs(); flushE = 1'b1; mem_stallM = 1'b1; settle();
    chk("prio_flush", {md_doneE, stallF, stallD, stallE, flushM}, 5'b00001);
    cyc(); idle_inputs(); settle();
    chk("prio_idle", {busy, dp_is_div, dp_divzero}, 3'b000);

    // Asynchronous reset in the middle of a MULHU.
    cyc(); accept(3'b011, 1'b0); settle();
    for (int i = 1; i <= 16; i++) begin
      cyc(); idle_inputs(); settle();
    end
    chk("rst_pre_cnt", iter_cnt, 6'd15);
    #1 rst = 1'b0;
    #1;
    chk("rst_async_outs", {busy, dp_load, dp_step, md_doneE, flushM, stallF, stallD, stallE}, 8'h00);
    chk("rst_async_cnt", {iter_cnt, dp_upper}, 7'h00);
    cyc(); rst = 1'b1; settle();
    chk("rst_release_idle", {busy, iter_cnt}, 7'h00);
    cyc(); accept(3'b011, 1'b0); settle();
    chk("mulhu_c0", {dp_load, busy}, 2'b10);
    for (int i = 1; i <= 32; i++) begin
      cyc(); idle_inputs(); settle();
    end
    cyc(); settle();
    chk("mulhu_done", {md_doneE, iter_cnt}, {1'b1, 6'd32});
    chk("mulhu_latch", {dp_is_div, dp_signed_a, dp_signed_b, dp_upper, dp_divzero}, 5'b00010);

    // Back-to-back MULs: second load right after the first DONE cycle.
    cyc(); accept(3'b000, 1'b0); settle();
    chk("b2b_first_load", dp_load, 1'b1);
    for (int i = 1; i <= 32; i++) begin
      cyc(); idle_inputs(); settle();
    end
    cyc(); settle();
    chk("b2b_first_done", md_doneE, 1'b1);
    cyc(); accept(3'b000, 1'b0); settle();
    chk("b2b_second_load", {dp_load, busy, stallE}, 3'b101);
    for (int i = 1; i <= 32; i++) begin
      cyc(); idle_inputs(); settle();
    end
    cyc(); settle();
    chk("b2b_second_done", {md_doneE, dp_step, iter_cnt}, {2'b10, 6'd32});
    cyc(); settle();
    chk("b2b_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
